// File: rtl/vacc_ctrl.sv
// rtl/vacc_ctrl.sv - read-add-write vector accumulator controller for an external SDP BRAM
module vacc_ctrl #(
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 32,
  parameter int VECTOR_LEN = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   acc_len,
  input  logic                          new_acc,
  input  logic [DIN_WIDTH-1:0]          din,
  input  logic                          din_valid,
  output logic                          bram_ren,
  output logic [$clog2(VECTOR_LEN)-1:0] bram_radd,
  input  logic [DOUT_WIDTH-1:0]         bram_wout,
  output logic                          bram_wen,
  output logic [$clog2(VECTOR_LEN)-1:0] bram_wadd,
  output logic [DOUT_WIDTH-1:0]         bram_win,
  output logic [DOUT_WIDTH-1:0]         dout,
  output logic                          dout_valid,
  output logic                          dout_sof
);

  localparam int AW = $clog2(VECTOR_LEN);

  logic [AW-1:0]         addr, addr_r, s_addr;
  logic [31:0]           vec_cnt, len_l, len_eff;
  logic                  first, last, s_first, s_last;
  logic [DIN_WIDTH-1:0]  din_r;
  logic                  valid_r, first_r, last_r;
  logic [DOUT_WIDTH-1:0] sum;

  always_comb begin
    len_eff   = (acc_len == 32'd0) ? 32'd1 : acc_len;
    first     = (vec_cnt == 32'd0);
    last      = (vec_cnt == len_l - 32'd1);
    // a sample arriving with new_acc is bin 0 of vector 0 under the new length
    s_addr    = new_acc ? '0 : addr;
    s_first   = new_acc | first;
    s_last    = new_acc ? (len_eff == 32'd1) : last;
    bram_ren  = din_valid & ~rst;
    bram_radd = s_addr;
    sum       = (first_r ? '0 : bram_wout) + DOUT_WIDTH'(din_r);
    bram_wen  = valid_r & ~rst;
    bram_wadd = addr_r;
    bram_win  = sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      vec_cnt    <= 32'd0;
      len_l      <= len_eff;
      valid_r    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
    end else begin
      valid_r <= din_valid;
      if (din_valid) begin
        din_r   <= din;
        addr_r  <= s_addr;
        first_r <= s_first;
        last_r  <= s_last;
      end
      dout       <= sum;
      dout_valid <= valid_r & last_r;
      dout_sof   <= valid_r & last_r & (addr_r == '0);
      if (new_acc) begin
        addr    <= din_valid ? AW'(1) : '0;
        vec_cnt <= 32'd0;
        len_l   <= len_eff;
      end else if (din_valid) begin
        addr <= addr + AW'(1);
        if (addr == '1) begin
          if (last) begin
            vec_cnt <= 32'd0;
            len_l   <= len_eff;
          end else begin
            vec_cnt <= vec_cnt + 32'd1;
          end
        end
      end
    end
  end

endmodule

// File: doc/vacc_ctrl.md
# vacc_ctrl

Unsigned vector-accumulator controller for the dual-port BRAM accumulation path. It receives a stream of VECTOR_LEN-sample vectors and drives an external simple-dual-port BRAM (one-cycle registered read, enable-gated). It performs a read-add-write of each sample into its bin. After acc_len vectors it emits the integrated vector on dout, and the next integration begins by overwriting the bins instead of adding to them.

## Interface
- DIN_WIDTH, 16, unsigned input sample width
- DOUT_WIDTH, 32, accumulator, BRAM word and output width; must be >= DIN_WIDTH
- VECTOR_LEN, 64, samples per vector; power of two, >= 2; BRAM depth
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- acc_len  in  32  vectors per integration; 0 is treated as 1
- new_acc  in  1  one-cycle pulse that aborts and restarts integration
- din  in  DIN_WIDTH  input sample
- din_valid  in  1  din qualifier; no backpressure
- bram_ren  out  1  BRAM read enable
- bram_radd  out  $clog2(VECTOR_LEN)  BRAM read address
- bram_wout  in  DOUT_WIDTH  BRAM read data, valid one cycle after bram_ren
- bram_wen  out  1  BRAM write enable
- bram_wadd  out  $clog2(VECTOR_LEN)  BRAM write address
- bram_win  out  DOUT_WIDTH  BRAM write data
- dout  out  DOUT_WIDTH  integrated bin value
- dout_valid  out  1  dout qualifier
- dout_sof  out  1  high with dout_valid on bin 0 of each output vector

## Operation
- addr counter: 0..VECTOR_LEN-1. Increments on each accepted din_valid and wraps to 0. On wrap, vec_cnt increments.
- vec_cnt: 0..len_l-1, where len_l is the latched acc_len (0 maps to 1). vec_cnt wraps to 0 after len_l-1; the wrap starts a new integration.
- len_l update: loaded from acc_len on rst, on new_acc, and whenever vec_cnt wraps. A mid-integration acc_len change takes effect only at the next integration.
- Derived flags: first = (vec_cnt==0); last = (vec_cnt==len_l-1). Both are true when len_l=1.
- Stage 0, cycle t, when din_valid:
  - bram_ren=1, bram_radd=addr, both combinational.
  - Register din_r, addr_r, first_r, last_r, and valid_r=1.
- Stage 1, cycle t+1:
  - sum = (first_r ? 0 : bram_wout) + zero-extended din_r, taken modulo 2^DOUT_WIDTH (wraps silently).
  - bram_wen=valid_r, bram_wadd=addr_r, bram_win=sum, all combinational.
- Output register at t+2:
  - dout <= sum.
  - dout_valid <= valid_r & last_r.
  - dout_sof <= valid_r & last_r & (addr_r==0).
- Hazard: VECTOR_LEN >= 2 guarantees that a bin's write (at t+1) precedes its next read (at t+VECTOR_LEN or later). No forwarding is needed.
- new_acc:
  - addr, vec_cnt and len_l are updated at the edge ending the cycle in which new_acc is high.
  - If din_valid is high in that same cycle, that sample is treated as addr 0, vector 0 (first=1, last computed from the new acc_len).
  - Any sample already in stage 1 completes its write and its dout normally.
- Gaps in din_valid: the pipeline stalls nothing; stage 1 and the output register simply carry valid=0.

## Timing
- Reset values: dout=0, dout_valid=0, dout_sof=0, bram_wen=0, bram_ren=0 (since din_valid is ignored during rst), addr=0, vec_cnt=0, pipeline valids=0.
- Latency: din_valid at cycle t gives bram_ren at t (combinational), bram_wen at t+1, and dout_valid at t+2.
- Throughput: one sample per clock, sustained.
- Output pattern: dout_valid is asserted only for samples of the last vector of each integration. The output is exactly VECTOR_LEN pulses per integration, with the same gap pattern as din_valid.
- rst mid-operation:
  - Discards stage 0 and stage 1 content; no BRAM write occurs for the in-flight sample.
  - The next integration starts at addr 0 with first=1, so stale BRAM contents are never read into a sum.

## Test plan
- VECTOR_LEN=4, acc_len=1, din=1,2,3,4 back-to-back -> dout=1,2,3,4. dout_valid high from 2 cycles after the first sample for 4 cycles; dout_sof on the first only.
- acc_len=3, 3 vectors of constant 10, then a 4th vector of 7 -> dout_valid only during vector 3, dout=30 for all bins. The 4th vector yields no output but is written as 7 (first overwrite), with no carry of 30.
- Same as the previous case but din_valid high every other cycle -> identical dout values; bram_wen asserted exactly one cycle after each bram_ren.
- DOUT_WIDTH=16, acc_len=2, din=0xFFFF -> dout=0xFFFE (modulo wrap).
- acc_len=2, new_acc pulsed at sample 2 of vector 1 (same cycle as din_valid with din=5), then feed 2 full vectors of 1 -> the sample in the new_acc cycle lands in bin 0 of the new vector 0. The final dout contains no pre-new_acc data.
- rst asserted for 1 cycle mid-vector; acc_len changed from 2 to 4 mid-integration without reset -> after rst, output only after 2 fresh vectors (latched value). The changed acc_len is applied from the following integration: 4 vectors, dout = 4× input.
